// File: rtl/mem_port_arb_pkg.sv
// Shared types for the unified memory port arbiter.
// Contents: arbiter state encoding, grant encoding, default widths and a
// small helper that tells whether a state owns the memory port.
package mem_port_arb_pkg;

    localparam int DEF_ADDR_W = 32;
    localparam int DEF_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        BUSY_MEM = 2'd1,
        BUSY_IF  = 2'd2,
        DONE     = 2'd3
    } arb_state_t;

    typedef enum logic {
        GNT_IF  = 1'b0,
        GNT_MEM = 1'b1
    } arb_grant_t;

    // True while an access is in flight on the memory port.
    function automatic logic arb_is_busy(input arb_state_t s);
        return (s == BUSY_MEM) || (s == BUSY_IF);
    endfunction

endpackage

// File: rtl/mem_port_arb_timeout.sv
// Watchdog counter for the memory port arbiter.
// Ports:
//   clk_i    - clock, rising edge
//   rst_i    - asynchronous active-low reset
//   start_i  - count this cycle (access in flight)
//   clear_i  - synchronously zero the count (no access in flight)
//   expire_o - high in the LIMIT-th consecutive counted cycle
module mem_port_arb_timeout #(
    parameter int unsigned LIMIT = 64
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic start_i,
    input  logic clear_i,
    output logic expire_o
);

    localparam int unsigned CNT_W = (LIMIT > 1) ? $clog2(LIMIT) : 1;

    logic [CNT_W-1:0] r_cnt;

    // Count busy cycles; restart from zero whenever the port goes idle.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_cnt <= '0;
        end else if (clear_i) begin
            r_cnt <= '0;
        end else if (start_i) begin
            r_cnt <= r_cnt + 1'b1;
        end else begin
            r_cnt <= r_cnt;
        end
    end

    // Count starts at 0 in the first busy cycle, so LIMIT-1 marks the last one.
    assign expire_o = start_i & (r_cnt == CNT_W'(LIMIT - 1));

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter sharing one memory port between instruction fetch
// (IF) and the MEM stage. MEM has fixed priority. One access at a time over
// a req/ack handshake; a one-cycle valid pulse returns the result.
// Optional feature macro: MEM_PORT_ARB_TIMEOUT_EN (watchdog abort + err_o).
// Ports:
//   clk_i, rst_i                 - clock, async active-low reset
//   if_req_i/if_addr_i           - fetch request; if_rdata_o/if_valid_o result
//   mem_read_i/mem_write_i, mem_addr_i, mem_wdata_i - EX/MEM request
//   mem_rdata_o/mem_valid_o      - load data / completion pulse
//   stall_o                      - pipeline freeze while a request is pending
//   port_req_o/we/addr/wdata     - memory request side (registered)
//   port_rdata_i/port_ack_i      - memory response side
//   err_o                        - sticky timeout flag (feature builds only)
module mem_port_arbiter
    import mem_port_arb_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic [DATA_W-1:0] if_rdata_o,
    output logic              if_valid_o,
    input  logic              mem_read_i,
    input  logic              mem_write_i,
    input  logic [ADDR_W-1:0] mem_addr_i,
    input  logic [DATA_W-1:0] mem_wdata_i,
    output logic [DATA_W-1:0] mem_rdata_o,
    output logic              mem_valid_o,
    output logic              stall_o,
    output logic              port_req_o,
    output logic              port_we_o,
    output logic [ADDR_W-1:0] port_addr_o,
    output logic [DATA_W-1:0] port_wdata_o,
    input  logic [DATA_W-1:0] port_rdata_i,
    input  logic              port_ack_i
`ifdef MEM_PORT_ARB_TIMEOUT_EN
    , output logic            err_o
`endif
);

    arb_state_t        r_state;
    arb_state_t        w_state_nxt;
    arb_grant_t        r_gnt;
    logic              r_port_req;
    logic              r_port_we;
    logic [ADDR_W-1:0] r_port_addr;
    logic [DATA_W-1:0] r_port_wdata;
    logic [DATA_W-1:0] r_if_rdata;
    logic [DATA_W-1:0] r_mem_rdata;
    logic              r_if_valid;
    logic              r_mem_valid;
    logic              w_mem_req;
    logic              w_abort;
    logic              w_done;
    logic [DATA_W-1:0] w_rd_data;

    assign w_mem_req = mem_read_i | mem_write_i;
    assign w_done    = port_ack_i | w_abort;
    // An aborted access returns zero instead of whatever is on the bus.
    assign w_rd_data = port_ack_i ? port_rdata_i : '0;

`ifdef MEM_PORT_ARB_TIMEOUT_EN
    logic w_expire;
    logic r_err;

    mem_port_arb_timeout #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .start_i  (arb_is_busy(r_state)),
        .clear_i  (~arb_is_busy(r_state)),
        .expire_o (w_expire)
    );

    // A real ack in the expiry cycle wins over the watchdog.
    assign w_abort = w_expire & ~port_ack_i;

    // Sticky error flag, cleared only by reset.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_err <= 1'b0;
        end else if (w_abort) begin
            r_err <= 1'b1;
        end else begin
            r_err <= r_err;
        end
    end

    assign err_o = r_err;
`else
    assign w_abort = 1'b0;
`endif

    // Next-state logic: MEM beats IF in IDLE; DONE always returns to IDLE.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_mem_req) begin
                    w_state_nxt = BUSY_MEM;
                end else if (if_req_i) begin
                    w_state_nxt = BUSY_IF;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            BUSY_MEM, BUSY_IF: begin
                if (w_done) begin
                    w_state_nxt = DONE;
                end else begin
                    w_state_nxt = r_state;
                end
            end
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // State, port request fields, result capture and valid pulses.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state      <= IDLE;
            r_gnt        <= GNT_IF;
            r_port_req   <= 1'b0;
            r_port_we    <= 1'b0;
            r_port_addr  <= '0;
            r_port_wdata <= '0;
            r_if_rdata   <= '0;
            r_mem_rdata  <= '0;
            r_if_valid   <= 1'b0;
            r_mem_valid  <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_if_valid  <= 1'b0;
            r_mem_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_mem_req) begin
                        // Read and write together executes as a write.
                        r_gnt        <= GNT_MEM;
                        r_port_req   <= 1'b1;
                        r_port_we    <= mem_write_i;
                        r_port_addr  <= mem_addr_i;
                        r_port_wdata <= mem_wdata_i;
                    end else if (if_req_i) begin
                        r_gnt        <= GNT_IF;
                        r_port_req   <= 1'b1;
                        r_port_we    <= 1'b0;
                        r_port_addr  <= if_addr_i;
                        r_port_wdata <= '0;
                    end else begin
                        r_port_req   <= 1'b0;
                    end
                end
                BUSY_MEM, BUSY_IF: begin
                    if (w_done) begin
                        r_port_req <= 1'b0;
                        if (r_gnt == GNT_MEM) begin
                            r_mem_valid <= 1'b1;
                            if (!r_port_we) begin
                                r_mem_rdata <= w_rd_data;
                            end
                        end else begin
                            r_if_valid <= 1'b1;
                            r_if_rdata <= w_rd_data;
                        end
                    end
                end
                DONE:    r_port_req <= 1'b0;
                default: r_port_req <= 1'b0;
            endcase
        end
    end

    assign stall_o      = (if_req_i & ~r_if_valid) | (w_mem_req & ~r_mem_valid);
    assign if_rdata_o   = r_if_rdata;
    assign if_valid_o   = r_if_valid;
    assign mem_rdata_o  = r_mem_rdata;
    assign mem_valid_o  = r_mem_valid;
    assign port_req_o   = r_port_req;
    assign port_we_o    = r_port_we;
    assign port_addr_o  = r_port_addr;
    assign port_wdata_o = r_port_wdata;

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-requester arbiter that shares the single unified memory port between the instruction-fetch stage and the MEM stage of the 5-stage pipeline. MEM-stage requests are driven from the EX/MEM register outputs (MemRead/MemWrite, address, write data). The block issues one access at a time over a req/ack memory handshake and returns the result to the winning requester. It also drives a pipeline-wide stall while any request is outstanding.

## Interface
- ADDR_W, 32, byte address width
- DATA_W, 32, data word width
- TIMEOUT_CYCLES, 64, watchdog limit; used only with the timeout feature
- clk_i  in  1  clock, rising edge
- rst_i  in  1  reset, asynchronous, active-low
- if_req_i  in  1  fetch read request; held high until if_valid_o
- if_addr_i  in  ADDR_W  fetch address
- if_rdata_o  out  DATA_W  fetched instruction word
- if_valid_o  out  1  one-cycle pulse; if_rdata_o is valid
- mem_read_i  in  1  MemRead from EX/MEM; held until mem_valid_o
- mem_write_i  in  1  MemWrite from EX/MEM; held until mem_valid_o
- mem_addr_i  in  ADDR_W  EX/MEM Address
- mem_wdata_i  in  DATA_W  EX/MEM Write_data
- mem_rdata_o  out  DATA_W  load data
- mem_valid_o  out  1  one-cycle pulse; load or store completed
- stall_o  out  1  freeze the PC and all pipeline registers
- port_req_o  out  1  memory request; held until ack
- port_we_o  out  1  1 = write
- port_addr_o  out  ADDR_W  memory address
- port_wdata_o  out  DATA_W  memory write data
- port_rdata_i  in  DATA_W  memory read data; valid when port_ack_i is high
- port_ack_i  in  1  memory completion; may be high in the first cycle port_req_o is high
- err_o  out  1  sticky timeout flag; exists only with the timeout feature

## Operation
- States: IDLE, BUSY_MEM, BUSY_IF, DONE.
- IDLE:
  - mem_read_i | mem_write_i → BUSY_MEM. MEM has fixed priority over IF because it carries the older instruction.
  - else if_req_i → BUSY_IF.
  - Address, write data and we are latched into port_*_o registers on the transition edge.
- BUSY_*: port_req_o = 1 and the latched fields are held stable. A sampled port_ack_i → DONE.
  - On a read ack, port_rdata_i is captured into if_rdata_o or mem_rdata_o.
- DONE: the matching valid pulse is high for exactly this cycle, then → IDLE unconditionally. No request is accepted in DONE, which prevents re-issue of a still-asserted request.
- stall_o = (if_req_i & ~if_valid_o) | ((mem_read_i | mem_write_i) & ~mem_valid_o). This is combinational from inputs and registered valids.
- mem_read_i & mem_write_i both high: executes as a write, and mem_rdata_o is not updated.
- A write leaves mem_rdata_o unchanged. rdata outputs hold their last value between accesses.
- Requests arriving while BUSY_*/DONE wait. The requester must not change its address while its request is held.

## Timing
- Reset values: state IDLE; all outputs 0, including rdata registers and err_o.
- Reset mid-access: port_req_o drops asynchronously and no valid pulse is produced. After reset release, held requests start again from IDLE.
- Minimum access, zero-wait memory:
  - edge 0: request sampled in IDLE.
  - cycle 1: port_req_o = 1, ack = 1.
  - cycle 2: DONE, valid = 1.
  - cycle 3: IDLE, next request accepted at the end of cycle 3.
  - Throughput is one access per 3 cycles.
- Each memory wait cycle adds one cycle of latency.
- Simultaneous IF and MEM requests: MEM completes first, then IF starts in the IDLE cycle after MEM's DONE. IF cannot starve, because MEM requests are bounded by the pipeline stall.

## Configuration
- MEM_PORT_ARB_TIMEOUT_EN defined:
  - A counter runs in BUSY_*. If TIMEOUT_CYCLES elapse without port_ack_i, the access is aborted: → DONE, valid pulses with rdata = 0, and err_o is set.
  - err_o stays set until reset.
- Not defined: BUSY_* waits indefinitely, err_o is absent, and no counter logic is built.

## Structure
- Package mem_port_arb_pkg: state enum (IDLE, BUSY_MEM, BUSY_IF, DONE), grant enum (GNT_IF, GNT_MEM), default widths.
- Sub-module mem_port_arb_timeout: watchdog counter with a start/clear/expire interface. It is instantiated only under MEM_PORT_ARB_TIMEOUT_EN.

## Test plan
- if_req_i=1, addr 0x10, zero-wait memory returning 0xDEADBEEF → port_req_o in cycle 1, if_valid_o in cycle 2, if_rdata_o=0xDEADBEEF, stall_o low from cycle 2.
- IF and mem_read_i both raised in the same cycle, addr 0x20 / 0x40 → MEM is served first (port_addr_o=0x40), then IF (0x20); stall_o stays high until if_valid_o.
- mem_write_i addr 0x8, data 0x1234, ack delayed 3 cycles → port_we_o=1 and address/data stable for 4 cycles; mem_valid_o pulses once; mem_rdata_o unchanged.
- rst_i asserted low in BUSY_IF → port_req_o=0 immediately and no if_valid_o; after release, the held request reissues.
- With MEM_PORT_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=4, no ack → after 4 busy cycles, valid pulses with rdata 0 and err_o=1, which stays set.
